// File: rtl/fir_folded_mc_if.sv
`timescale 1ns/1ps
// Sample, result and coefficient-write signals of fir_folded_mc.
// The master side is the sample source / result consumer; the slave side is the filter.
interface fir_folded_mc_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32,
    parameter int CH_W   = 1,
    parameter int ADDR_W = 8
);
    logic signed [DATA_W-1:0] x_in;
    logic        [CH_W-1:0]   x_ch;
    logic                     x_valid;
    logic                     x_ready;
    logic                     coef_we;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_err;
    logic signed [OUT_W-1:0]  y_out;
    logic        [CH_W-1:0]   y_ch;
    logic                     y_valid;
    logic                     y_ready;

    modport master (
        output x_in, x_ch, x_valid, coef_we, coef_addr, coef_wdata, y_ready,
        input  x_ready, coef_err, y_out, y_ch, y_valid
    );

    modport slave (
        input  x_in, x_ch, x_valid, coef_we, coef_addr, coef_wdata, y_ready,
        output x_ready, coef_err, y_out, y_ch, y_valid
    );
endinterface

// File: rtl/fir_folded_mc.sv
`timescale 1ns/1ps
// Time-multiplexed multi-channel FIR: one MAC walks all taps per accepted sample,
// then rounds, saturates and holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a sample, x_ready high
// MAC   | one tap per cycle, TAPS cycles
// ROUND | round, saturate and register the result
// OUT   | y_valid high until the consumer accepts
module fir_folded_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 175,
    parameter int CHANNELS = 1,
    parameter int ACC_W    = 48,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    fir_folded_mc_if.slave  bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(1) << SHIFT;
    localparam logic signed [ACC_W-1:0]  RND_HALF   = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [OUT_W-1:0]  OUT_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0]  OUT_MIN    = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t state, state_nx;

    logic signed [DATA_W-1:0] dline [CHANNELS][TAPS];
    logic        [TAP_W-1:0]  head  [CHANNELS];
    logic signed [COEF_W-1:0] coef  [TAPS];

    logic        [TAP_W-1:0]  pos_q;
    logic        [TAP_W-1:0]  k_q;
    logic        [CH_W-1:0]   ch_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  y_out_q;
    logic        [CH_W-1:0]   y_ch_q;
    logic                     coef_err_q;

    logic                     ch_ok;
    logic                     addr_ok;
    logic                     accept;
    logic                     coef_wr_ok;
    logic                     last_tap;
    logic        [TAP_W:0]    wrap_idx;
    logic        [TAP_W-1:0]  rd_idx;
    logic signed [DATA_W-1:0] samp;
    logic signed [COEF_W-1:0] cf;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  r;
    logic        [ACC_W-OUT_W:0] r_hi;
    logic signed [OUT_W-1:0]  sat_val;

    assign ch_ok      = ({1'b0, bus.x_ch} < (CH_W+1)'(CHANNELS));
    assign addr_ok    = ({1'b0, bus.coef_addr} < (TAP_W+1)'(TAPS));
    assign accept     = (state == IDLE) && bus.x_valid && ch_ok;
    assign coef_wr_ok = bus.coef_we && addr_ok && ((state == IDLE) || (state == OUT));
    assign last_tap   = (k_q == TAP_W'(TAPS - 1));

    // Tap k reads the sample k positions older than the newest one, wrapping the ring.
    assign wrap_idx = {1'b0, pos_q} + (TAP_W+1)'(TAPS) - {1'b0, k_q};
    assign rd_idx   = (k_q > pos_q) ? wrap_idx[TAP_W-1:0] : (pos_q - k_q);

    assign samp     = dline[ch_q][rd_idx];
    assign cf       = coef[k_q];
    assign prod     = samp * cf;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    assign rnd_sum  = acc + RND_HALF;
    assign r        = rnd_sum >>> SHIFT;
    assign r_hi     = r[ACC_W-1:OUT_W-1];

    always_comb begin
        sat_val = r[OUT_W-1:0];
        if (!((&r_hi) || (~|r_hi))) begin
            sat_val = r[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (last_tap) state_nx = ROUND;
            ROUND:   state_nx = OUT;
            OUT:     if (bus.y_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            k_q        <= '0;
            ch_q       <= '0;
            acc        <= '0;
            y_out_q    <= '0;
            y_ch_q     <= '0;
            coef_err_q <= 1'b0;
        end else begin
            coef_err_q <= bus.coef_we && !coef_wr_ok;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pos_q <= head[bus.x_ch];
                        ch_q  <= bus.x_ch;
                        acc   <= '0;
                        k_q   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k_q <= k_q + 1'b1;
                end
                ROUND: begin
                    y_out_q <= sat_val;
                    y_ch_q  <= ch_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                head[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    dline[c][t] <= '0;
                end
            end
        end else if (accept) begin
            dline[bus.x_ch][head[bus.x_ch]] <= bus.x_in;
            head[bus.x_ch] <= (head[bus.x_ch] == TAP_W'(TAPS - 1)) ? '0 : head[bus.x_ch] + 1'b1;
        end
    end

    // Reset leaves the filter as a pass-through: unity on tap 0 only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TAPS; t++) begin
                coef[t] <= (t == 0) ? COEF_UNITY : '0;
            end
        end else if (coef_wr_ok) begin
            coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    assign bus.x_ready  = (state == IDLE);
    assign bus.y_valid  = (state == OUT);
    assign bus.y_out    = y_out_q;
    assign bus.y_ch     = y_ch_q;
    assign bus.coef_err = coef_err_q;

endmodule

// File: tb/tb_fir_folded_mc.sv
`timescale 1ns/1ps
// Directed bench for fir_folded_mc: table of coefficient writes, resets and samples,
// followed by hand-written drop, backpressure, illegal-write and mid-MAC reset sequences.
module tb_fir_folded_mc;
    localparam int DATA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int TAPS     = 4;
    localparam int CHANNELS = 3;
    localparam int ACC_W    = 48;
    localparam int OUT_W    = 16;
    localparam int SHIFT    = 8;
    localparam int CH_W     = 2;
    localparam int ADDR_W   = 2;

    localparam int OP_RST = 0;
    localparam int OP_WC  = 1;
    localparam int OP_SMP = 2;

    typedef struct {
        int op;
        int a;
        int d;
        int ey;
        int ech;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_folded_mc_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W),
                       .CH_W(CH_W), .ADDR_W(ADDR_W)) bus ();

    fir_folded_mc #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS),
        .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int op, input int a, input int d, input int ey, input int ech);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.ey = ey; v.ech = ech;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr_coef(input int addr, input int d, output int err);
        logic [31:0] dv;
        dv = d;
        bus.coef_we    = 1'b1;
        bus.coef_addr  = addr[ADDR_W-1:0];
        bus.coef_wdata = dv[COEF_W-1:0];
        tick();
        err = int'(bus.coef_err);
        bus.coef_we = 1'b0;
    endtask

    // Present one sample, then wait for y_valid. lat counts the accept cycle as 1.
    task automatic send(input int ch, input int x, output int y, output int ych,
                        output int lat, output int acc_cyc, output int xr_bad);
        logic [31:0] xv;
        int g;
        xv = x;
        bus.x_ch    = ch[CH_W-1:0];
        bus.x_in    = xv[DATA_W-1:0];
        bus.x_valid = 1'b1;
        g = 0;
        while (!bus.x_ready && g < 50) begin
            tick();
            g++;
        end
        check("x_ready_before_accept", int'(bus.x_ready), 1);
        tick();
        acc_cyc = cyc;
        bus.x_valid = 1'b0;
        lat = 1;
        xr_bad = 0;
        while (!bus.y_valid && lat < 40) begin
            if (bus.x_ready) xr_bad++;
            tick();
            lat++;
        end
        if (bus.x_ready) xr_bad++;
        y   = int'($signed(bus.y_out));
        ych = int'(bus.y_ch);
    endtask

    task automatic take();
        bus.y_ready = 1'b1;
        tick();
        check("y_valid_after_handshake", int'(bus.y_valid), 0);
        check("x_ready_after_handshake", int'(bus.x_ready), 1);
    endtask

    initial begin
        int y, ych, lat, acc_c, xr_bad, err, prev_acc, bad, g;
        bit prev_smp;
        logic signed [OUT_W-1:0] hold_y;

        bus.x_in = '0; bus.x_ch = '0; bus.x_valid = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
        bus.y_ready = 1'b1;

        // Reset values while rst_n is held low.
        tick();
        check("rst_x_ready",  int'(bus.x_ready), 1);
        check("rst_y_valid",  int'(bus.y_valid), 0);
        check("rst_y_out",    int'($signed(bus.y_out)), 0);
        check("rst_y_ch",     int'(bus.y_ch), 0);
        check("rst_coef_err", int'(bus.coef_err), 0);
        rst_n = 1'b1;
        tick();

        // Pass-through after reset.
        add(OP_RST, 0, 0, 0, 0);
        add(OP_SMP, 0, 100, 100, 0);
        add(OP_SMP, 0, -200, -200, 0);
        add(OP_SMP, 0, 7, 7, 0);
        // Impulse response.
        add(OP_RST, 0, 0, 0, 0);
        add(OP_WC, 0, 256, 0, 0);
        add(OP_WC, 1, 512, 0, 0);
        add(OP_WC, 2, -256, 0, 0);
        add(OP_WC, 3, 0, 0, 0);
        add(OP_SMP, 0, 100, 100, 0);
        add(OP_SMP, 0, 0, 200, 0);
        add(OP_SMP, 0, 0, -100, 0);
        add(OP_SMP, 0, 0, 0, 0);
        add(OP_SMP, 0, 0, 0, 0);
        // Round-half-up with coef[0]=1.
        add(OP_RST, 0, 0, 0, 0);
        add(OP_WC, 0, 1, 0, 0);
        add(OP_SMP, 0, 128, 1, 0);
        add(OP_SMP, 0, 127, 0, 0);
        add(OP_SMP, 0, -128, 0, 0);
        add(OP_SMP, 0, -129, -1, 0);
        // Saturation to 16-bit output.
        add(OP_RST, 0, 0, 0, 0);
        for (int t = 0; t < TAPS; t++) add(OP_WC, t, 32767, 0, 0);
        for (int t = 0; t < 4; t++) add(OP_SMP, 0, 32767, 32767, 0);
        add(OP_SMP, 0, -32768, 32767, 0);
        add(OP_SMP, 0, -32768, -256, 0);
        add(OP_SMP, 0, -32768, -32768, 0);
        add(OP_SMP, 0, -32768, -32768, 0);
        // Channel isolation with taps 0 and 1 at unity.
        add(OP_RST, 0, 0, 0, 0);
        add(OP_WC, 1, 256, 0, 0);
        add(OP_SMP, 0, 50, 50, 0);
        add(OP_SMP, 1, 30, 30, 1);
        add(OP_SMP, 0, 10, 60, 0);
        add(OP_SMP, 2, -5, -5, 2);

        prev_smp = 1'b0;
        prev_acc = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_RST: begin
                    do_reset();
                    prev_smp = 1'b0;
                end
                OP_WC: begin
                    wr_coef(vecs[i].a, vecs[i].d, err);
                    check($sformatf("coef_err[%0d]", i), err, 0);
                    prev_smp = 1'b0;
                end
                default: begin
                    send(vecs[i].a, vecs[i].d, y, ych, lat, acc_c, xr_bad);
                    check($sformatf("y_out[%0d]", i), y, vecs[i].ey);
                    check($sformatf("y_ch[%0d]", i), ych, vecs[i].ech);
                    check($sformatf("latency[%0d]", i), lat, TAPS + 2);
                    check($sformatf("x_ready_busy[%0d]", i), xr_bad, 0);
                    if (prev_smp) check($sformatf("period[%0d]", i), acc_c - prev_acc, TAPS + 3);
                    take();
                    prev_smp = 1'b1;
                    prev_acc = acc_c;
                end
            endcase
        end

        // Sample on a non-existent channel is dropped without error.
        bus.x_ch = 2'd3; bus.x_in = 16'sd999; bus.x_valid = 1'b1;
        tick();
        bus.x_valid = 1'b0;
        check("drop_x_ready", int'(bus.x_ready), 1);
        check("drop_coef_err", int'(bus.coef_err), 0);
        bad = 0;
        repeat (8) begin
            tick();
            if (bus.y_valid || !bus.x_ready) bad++;
        end
        check("drop_no_activity", bad, 0);
        send(0, 0, y, ych, lat, acc_c, xr_bad);
        check("drop_ch0_intact", y, 10);
        take();

        // Backpressure: result and channel held, x_ready low; a write during OUT is accepted.
        bus.y_ready = 1'b0;
        send(1, 0, y, ych, lat, acc_c, xr_bad);
        check("bp_y_out", y, 30);
        check("bp_y_ch", ych, 1);
        hold_y = bus.y_out;
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.y_out !== hold_y || bus.y_ch !== 2'd1 || !bus.y_valid || bus.x_ready) bad++;
        end
        check("bp_stable", bad, 0);
        wr_coef(2, 256, err);
        check("out_write_err", err, 0);
        check("out_write_y_valid", int'(bus.y_valid), 1);
        take();
        send(1, 0, y, ych, lat, acc_c, xr_bad);
        check("out_write_effect", y, 30);
        take();

        // Coefficient write during MAC is rejected with a one-cycle pulse.
        bus.x_ch = 2'd0; bus.x_in = 16'sd40; bus.x_valid = 1'b1;
        tick();
        bus.x_valid = 1'b0;
        tick();
        wr_coef(0, 999, err);
        check("mac_write_err", err, 1);
        tick();
        check("mac_write_err_pulse", int'(bus.coef_err), 0);
        g = 0;
        while (!bus.y_valid && g < 20) begin
            tick();
            g++;
        end
        check("mac_write_y_valid", int'(bus.y_valid), 1);
        check("mac_write_coef_kept", int'($signed(bus.y_out)), 50);
        take();

        // Asynchronous reset mid-MAC discards the pending result and restores pass-through.
        bus.x_ch = 2'd0; bus.x_in = 16'sd1000; bus.x_valid = 1'b1;
        tick();
        bus.x_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_y_valid", int'(bus.y_valid), 0);
        check("midrst_x_ready", int'(bus.x_ready), 1);
        check("midrst_y_out", int'($signed(bus.y_out)), 0);
        tick();
        rst_n = 1'b1;
        tick();
        send(0, 77, y, ych, lat, acc_c, xr_bad);
        check("midrst_pass_77", y, 77);
        take();
        send(0, 5, y, ych, lat, acc_c, xr_bad);
        check("midrst_pass_5", y, 5);
        take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_folded_mc.md
Name: fir_folded_mc

Overview:
- Parametrised, time-multiplexed multi-channel FIR filter. Successor to the fully parallel single-channel FIR.
- One MAC unit iterates over all taps per accepted sample.
- Coefficients are run-time writable. Output is rounded and saturated.
- Input and output use valid/ready handshakes, so the block sits between a sample source and a downstream consumer that may stall.

Parameters:
- DATA_W, 16, input sample width, signed Q1.(DATA_W-1)
- COEF_W, 16, coefficient width, signed
- TAPS, 175, taps per channel (>=2)
- CHANNELS, 1, number of independent channels, each with its own delay line, shared coefficients (>=1)
- ACC_W, 48, accumulator width, signed; must be >= DATA_W+COEF_W+clog2(TAPS)
- OUT_W, 32, output width, signed
- SHIFT, 8, rounding right-shift applied to the accumulator (1 <= SHIFT <= COEF_W-2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- x_in  in  DATA_W  input sample
- x_ch  in  max(1,clog2(CHANNELS))  channel of x_in
- x_valid  in  1  sample valid
- x_ready  out  1  block can accept a sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index to write
- coef_wdata  in  COEF_W  coefficient value
- coef_err  out  1  one-cycle pulse: write rejected
- y_out  out  OUT_W  filtered result
- y_ch  out  max(1,clog2(CHANNELS))  channel of y_out
- y_valid  out  1  result valid
- y_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; x_ready=1; y_valid=0; y_out=0; y_ch=0; coef_err=0.
  - All delay-line entries cleared to 0.
  - coef[0]=1<<SHIFT, all other coefs 0 (identity/pass-through).
- FSM states: IDLE, MAC, ROUND, OUT.
- IDLE:
  - x_ready=1.
  - On x_valid&&x_ready: write x_in at the head of channel x_ch's circular delay line, advance that channel's head (wraps TAPS-1->0), latch channel, clear acc, tap counter k=0. Go to MAC.
  - Only the selected channel's line/head changes.
  - x_ch >= CHANNELS: sample dropped, no state change, coef_err not asserted.
- MAC:
  - x_ready=0.
  - Each cycle: acc += sample[head-k mod TAPS] * coef[k], sign-extended full product, k++.
  - Tap 0 is the newest sample. After k=TAPS-1, go to ROUND. Exactly TAPS cycles.
- ROUND, one cycle:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round-half-up).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register into y_out, latched channel into y_ch. Go to OUT.
- OUT:
  - y_valid=1; y_out and y_ch held stable until y_valid&&y_ready.
  - On that handshake: y_valid=0 next cycle, go to IDLE.
  - Min accept-to-y_valid latency is TAPS+2 cycles; throughput is one sample per TAPS+3 cycles with y_ready tied high.
- Coefficient writes:
  - Accepted only in IDLE or OUT: coef[coef_addr] <= coef_wdata next cycle.
  - A write in MAC or ROUND, or with coef_addr >= TAPS, is ignored and coef_err pulses for 1 cycle.
  - A write in IDLE coincident with a sample accept takes effect for that sample's MAC pass.
- No overflow wrap in acc is permitted at legal ACC_W. Saturation happens only at the output stage.
- Reset mid-MAC or mid-OUT: pending result is discarded and every reset value above applies immediately.

Test Plan:
- Reset pass-through (TAPS=4, CHANNELS=1): samples 100, -200, 7 with y_ready=1 -> y_out 100, -200, 7; y_valid rises exactly TAPS+2=6 cycles after each accept; x_ready low from accept until the OUT handshake.
- Impulse response: write coefs 256, 512, -256, 0; then samples 100, 0, 0, 0, 0 -> y_out 100, 200, -100, 0, 0.
- Rounding (coef[0]=1, others 0, SHIFT=8): x=128, 127, -128, -129 -> y_out 1, 0, 0, -1.
- Saturation (OUT_W=16, all coefs 0x7FFF): four samples of 0x7FFF -> final y_out 32767; all coefs 0x7FFF and x=0x8000 repeated -> y_out -32768.
- Channel isolation (CHANNELS=2, identity coefs plus coef[1]=256):
  - ch0 gets 50, then ch1 gets 30 -> ch1 result 30 with y_ch=1.
  - ch0 then gets 10 -> result 60 with y_ch=0.
- Backpressure and illegal write: hold y_ready=0 for 10 cycles -> y_out/y_ch stable and x_ready=0; coef_we during MAC -> coef_err 1-cycle pulse and coefficient unchanged; assert rst_n low mid-MAC -> y_valid=0, x_ready=1, pass-through restored.
